ext_arbiter: RTL and testbench
==============================

// Module: ext_arbiter
// PURPOSE
//  Shares one IN_W->OUT_W sign-extension unit between two requesters:
//  req 0 = decode immediate path, req 1 = signed byte-load path.
//  Round-robin arbitration, valid/ready handshakes on both sides and a
//  one-entry registered output. Sits between decode/load units and the ALU operand mux.
// PARAMETERS
//  IN_W   8   input field width
//  OUT_W  16  extended result width; OUT_W > IN_W, else $error at elaboration
// PORTS
//  clk          in   1          rising-edge clock, single clock domain
//  rst_n        in   1          asynchronous reset, active low
//  req_valid    in   2          per-requester request valid
//  req_ready    out  2          per-requester accept (grant & slot free)
//  req_data0    in   IN_W       requester 0 operand
//  req_data1    in   IN_W       requester 1 operand
//  req_zext     in   2          per-requester zero-extend select (EXT_ZEXT_EN only)
//  rsp_valid    out  1          result valid
//  rsp_ready    in   1          consumer accepts result
//  rsp_data     out  OUT_W      extended result
//  rsp_id       out  1          requester index that produced rsp_data
// BEHAVIOUR
//  Reset (async, rst_n=0): rsp_valid=0, rsp_data=0, rsp_id=0, last_gnt=1
//   (req 0 wins the first tie). req_ready=2'b00 while rst_n=0.
//   An in-flight result is discarded immediately, without a clock edge.
//  FSM: EMPTY (rsp_valid=0) / FULL (rsp_valid=1).
//   slot_free = EMPTY | (FULL & rsp_ready).
//   EMPTY->FULL on accept. FULL->EMPTY on rsp_ready with no accept.
//   FULL->FULL on rsp_ready with accept (back-to-back) or on !rsp_ready (hold).
//  Arbitration (combinational):
//   - One valid: that requester is granted.
//   - Both valid: grant the requester != last_gnt.
//   - None valid: no grant.
//   req_ready[i] = gnt[i] & slot_free. Accept = req_valid[i] & req_ready[i].
//   last_gnt updates only on accept; never on an ungranted or idle cycle.
//  Datapath: on accept, at the same edge:
//   rsp_data <= {{(OUT_W-IN_W){d[IN_W-1]}}, d}, rsp_id <= i.
//   Latency 1 cycle accept->rsp_valid. Throughput 1/cycle while rsp_ready=1.
//  Backpressure: FULL & !rsp_ready -> rsp_data/rsp_id held stable, req_ready=0.
//  Protocol rules:
//   - Requester keeps req_valid/data stable until accepted; req_valid must not
//     depend on req_ready.
//   - rsp_valid never drops without rsp_ready.
//   - req_ready may depend on req_valid of both requesters; no path from
//     rsp_ready to rsp_valid.
//  Starvation: both continuously valid -> strict alternation; neither waits
//   more than one accept.
// CONFIGURATION
//  EXT_ZEXT_EN defined: req_zext port present. On accept, req_zext[i]=1 fills
//   the upper bits with 0 instead of d[IN_W-1]; zext is captured with the data.
//  EXT_ZEXT_EN undefined: req_zext port absent; every result is sign-extended.
// TESTING
//  1 rst_n=0 with req_valid=2'b11 -> req_ready=2'b00, rsp_valid=0, rsp_data=16'h0000.
//  2 req_valid=01, req_data0=8'h85, rsp_ready=1 -> next cycle rsp_valid=1,
//    rsp_data=16'hFF85, rsp_id=0.
//  3 req_valid=11 held, data0=8'h7F, data1=8'h80, rsp_ready=1 -> rsp_id 0,1,0,1...;
//    rsp_data 16'h007F/16'hFF80 alternating, one result per cycle.
//  4 FULL, rsp_ready=0 for 3 cycles -> rsp_data/rsp_id constant, req_ready=00;
//    rsp_ready=1 -> pending requester accepted the same edge, new rsp next cycle.
//  5 rst_n pulled low mid-cycle with rsp_valid=1 -> rsp_valid=0 before next edge;
//    after release, req_valid=11 -> first grant is req 0.
//  6 EXT_ZEXT_EN, req1 data=8'h80, zext=1 -> rsp_data=16'h0080;
//    macro undefined -> rsp_data=16'hFF80.

Source files
------------

// File: rtl/ext_arbiter_if.sv
// Handshake bundle between the two requesters, the shared sign-extension unit and its consumer.
// Optional req_zext is present only when EXT_ZEXT_EN is defined.
interface ext_arbiter_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [IN_W-1:0]  req_data0;
  logic [IN_W-1:0]  req_data1;
`ifdef EXT_ZEXT_EN
  logic [1:0]       req_zext;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [OUT_W-1:0] rsp_data;
  logic             rsp_id;

`ifdef EXT_ZEXT_EN
  modport master (output req_valid, req_data0, req_data1, req_zext, rsp_ready,
                  input  req_ready, rsp_valid, rsp_data, rsp_id);
  modport slave  (input  req_valid, req_data0, req_data1, req_zext, rsp_ready,
                  output req_ready, rsp_valid, rsp_data, rsp_id);
`else
  modport master (output req_valid, req_data0, req_data1, rsp_ready,
                  input  req_ready, rsp_valid, rsp_data, rsp_id);
  modport slave  (input  req_valid, req_data0, req_data1, rsp_ready,
                  output req_ready, rsp_valid, rsp_data, rsp_id);
`endif
endinterface

// File: rtl/ext_arbiter.sv
// Round-robin shared IN_W->OUT_W extension unit with a one-entry registered output.
// Define EXT_ZEXT_EN to add per-requester zero-extend select (req_zext).
//
// state | meaning
// EMPTY | no result held, rsp_valid=0
// FULL  | result held in rsp_data/rsp_id, rsp_valid=1
module ext_arbiter #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ext_arbiter_if.slave    bus
);

  if (OUT_W <= IN_W) begin : g_width_check
    $error("ext_arbiter: OUT_W must exceed IN_W");
  end

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic             last_gnt;
  logic [OUT_W-1:0] data_q;
  logic             id_q;

  logic [1:0]       gnt;
  logic             slot_free;
  logic             accept;
  logic             sel;
  logic [IN_W-1:0]  sel_data;
  logic             sel_zext;
  logic [OUT_W-1:0] ext_data;

  always_comb begin
    gnt = 2'b00;
    case (bus.req_valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign slot_free     = (state == EMPTY) || bus.rsp_ready;
  // Gated by rst_n so nothing is offered while reset is asserted.
  assign bus.req_ready = (rst_n && slot_free) ? gnt : 2'b00;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign sel           = gnt[1];
  assign sel_data      = sel ? bus.req_data1 : bus.req_data0;

`ifdef EXT_ZEXT_EN
  assign sel_zext = bus.req_zext[sel];
`else
  assign sel_zext = 1'b0;
`endif

  assign ext_data = {{(OUT_W-IN_W){sel_data[IN_W-1] & ~sel_zext}}, sel_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      data_q   <= '0;
      id_q     <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      if (accept) begin
        state    <= FULL;
        data_q   <= ext_data;
        id_q     <= sel;
        last_gnt <= sel;
      end else if (bus.rsp_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// Directed bench for ext_arbiter: reset, sign extension, alternation, backpressure,
// async reset mid-flight and the optional zero-extend select.
module tb_ext_arbiter;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  ext_arbiter_if #(.IN_W(8), .OUT_W(16)) bus ();

  ext_arbiter #(.IN_W(8), .OUT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_data;
    logic        exp_id;
    n_tests = 0;
    n_fail  = 0;

    // 1: reset with both requesters valid
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_data0 = 8'h00;
    bus.req_data1 = 8'h00;
`ifdef EXT_ZEXT_EN
    bus.req_zext = 2'b00;
`endif
    bus.rsp_ready = 1'b1;
    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
    bus.req_valid = 2'b00;
    #2 rst_n = 1'b1;
    tick();

    // 2: single requester, negative byte
    bus.req_valid = 2'b01;
    bus.req_data0 = 8'h85;
    #1 chk("t2_req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t2_rsp_data",  32'(bus.rsp_data),  32'hFF85);
    chk("t2_rsp_id",    32'(bus.rsp_id),    32'h0);
    tick();
    chk("t2_drain", 32'(bus.rsp_valid), 32'h0);

    // 3: both valid; last winner was req 0, so req 1 leads the alternation
    bus.req_valid = 2'b11;
    bus.req_data0 = 8'h7F;
    bus.req_data1 = 8'h80;
    exp_id = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("t3_req_ready", 32'(bus.req_ready), exp_id ? 32'h2 : 32'h1);
      tick();
      exp_data = exp_id ? 16'hFF80 : 16'h007F;
      chk("t3_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("t3_rsp_id",    32'(bus.rsp_id),    32'(exp_id));
      chk("t3_rsp_data",  32'(bus.rsp_data),  32'(exp_data));
      exp_id = ~exp_id;
    end

    // 4: backpressure holds req 0's result, then req 1 is accepted on release
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_hold_ready", 32'(bus.req_ready), 32'h0);
      tick();
      chk("t4_hold_valid", 32'(bus.rsp_valid), 32'h1);
      chk("t4_hold_id",    32'(bus.rsp_id),    32'h0);
      chk("t4_hold_data",  32'(bus.rsp_data),  32'h007F);
    end
    bus.rsp_ready = 1'b1;
    #1 chk("t4_release_ready", 32'(bus.req_ready), 32'h2);
    tick();
    chk("t4_next_id",   32'(bus.rsp_id),   32'h1);
    chk("t4_next_data", 32'(bus.rsp_data), 32'hFF80);

    // 5: asynchronous reset between edges discards the held result
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t5_rsp_data",  32'(bus.rsp_data),  32'h0);
    chk("t5_req_ready", 32'(bus.req_ready), 32'h0);
    #1 rst_n = 1'b1;
    #1 chk("t5_first_gnt", 32'(bus.req_ready), 32'h1);
    tick();
    chk("t5_first_id",   32'(bus.rsp_id),   32'h0);
    chk("t5_first_data", 32'(bus.rsp_data), 32'h007F);

    // 6: req 1 alone with zero-extend requested where supported
    bus.req_valid = 2'b10;
    bus.req_data1 = 8'h80;
`ifdef EXT_ZEXT_EN
    bus.req_zext = 2'b10;
`endif
    tick();
    bus.req_valid = 2'b00;
`ifdef EXT_ZEXT_EN
    bus.req_zext = 2'b00;
    chk("t6_zext_data", 32'(bus.rsp_data), 32'h0080);
`else
    chk("t6_sext_data", 32'(bus.rsp_data), 32'hFF80);
`endif
    chk("t6_id", 32'(bus.rsp_id), 32'h1);

    // idle cycles must not move last_gnt (still req 1), so a tie goes to req 0
    tick();
    chk("idle_empty", 32'(bus.rsp_valid), 32'h0);
    tick();
    bus.req_valid = 2'b11;
    bus.req_data0 = 8'h01;
    #1 chk("idle_tie_gnt", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    chk("idle_tie_data", 32'(bus.rsp_data), 32'h0001);
    chk("idle_tie_id",   32'(bus.rsp_id),   32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
